// File: rtl/exc_seq.sv
// Exception/interrupt/ERET sequencer that owns the single CP0 write port.
// The sequencer accepts one event while idle and writes EPC and/or Status,
// one register per cycle, with the pipeline stalled. It then issues a
// one-cycle flush and redirect. While idle with no event pending, pipeline
// MTC0 writes pass straight through to the CP0 write port.
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        eret_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        timer_int_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [4:0]  exc_code_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_EPC    = 3'd1,
    WR_STATUS = 3'd2,
    ERET_ST   = 3'd3,
    REDIRECT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [4:0]  code_q, code_d;

  logic int_pend;
  logic any_event;
  logic unused_cause;

  // Interrupt enable (IE=1, EXL=0) masked against pending lines; the timer
  // is folded into IP7.
  assign int_pend  = status_i[0] & ~status_i[1] &
                     (|(status_i[15:8] & {cause_i[15] | timer_int_i, cause_i[14:8]}));
  assign any_event = exc_req_i | int_pend | eret_i;

  assign unused_cause = ^{cause_i[31:16], cause_i[7:0]};

  // Next-state and latch update: exception beats interrupt beats ERET.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (exc_req_i || int_pend) begin
          pc_d    = exc_pc_i;
          code_d  = exc_req_i ? exc_code_i : 5'd0;
          state_d = status_i[1] ? WR_STATUS : WR_EPC;
        end else if (eret_i) begin
          target_d = epc_i;
          state_d  = ERET_ST;
        end
      end
      WR_EPC:    state_d = WR_STATUS;
      WR_STATUS: begin
        target_d = EXC_VECTOR;
        state_d  = REDIRECT;
      end
      ERET_ST:   state_d = REDIRECT;
      REDIRECT:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and latch registers; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= 32'd0;
      target_q <= 32'd0;
      code_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      code_q   <= code_d;
    end
  end

  // Output decode from the current state. MTC0 pass-through is gated by
  // reset because IDLE is also the reset state.
  always_comb begin
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_data_o  = 32'd0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    new_pc_o    = 32'd0;
    case (state_q)
      IDLE: begin
        if (rst && !any_event) begin
          cp0_we_o    = mtc0_we_i;
          cp0_waddr_o = mtc0_addr_i;
          cp0_data_o  = mtc0_data_i;
        end
      end
      WR_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_EPC;
        cp0_data_o  = pc_q;
        stall_o     = 1'b1;
      end
      WR_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = status_i | 32'h0000_0002;
        stall_o     = 1'b1;
      end
      ERET_ST: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = status_i & ~32'h0000_0002;
        stall_o     = 1'b1;
      end
      REDIRECT: begin
        flush_o  = 1'b1;
        new_pc_o = target_q;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign exc_code_o = code_q;

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq: inputs change on the falling edge, outputs are
// sampled 1 ns later, so every check sits well clear of the rising edge.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        eret_i;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic [31:0] mtc0_data_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        timer_int_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [4:0]  exc_code_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  exc_seq dut (
    .clk(clk), .rst(rst),
    .exc_req_i(exc_req_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .eret_i(eret_i),
    .mtc0_we_i(mtc0_we_i), .mtc0_addr_i(mtc0_addr_i), .mtc0_data_i(mtc0_data_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .exc_code_o(exc_code_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    exc_req_i = 1'b0; exc_code_i = 5'd0; exc_pc_i = 32'd0; eret_i = 1'b0;
    mtc0_we_i = 1'b0; mtc0_addr_i = 5'd0; mtc0_data_i = 32'd0;
    status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0; timer_int_i = 1'b0;
  endtask

  // Advance to the next falling edge, then settle.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    mtc0_we_i = 1'b1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h1234;
    next_cycle();
    n_checks++; if (cp0_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", cp0_we_o); end
    n_checks++; if ({stall_o, flush_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b want 000", {stall_o, flush_o, busy_o}); end
    n_checks++; if (new_pc_o !== 32'd0 || exc_code_o !== 5'd0) begin n_fail++; $display("FAIL rst_regs got pc=%h code=%h want 0/0", new_pc_o, exc_code_o); end
    clear_inputs();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_exception();
    exc_req_i = 1'b1; exc_code_i = 5'h0C; exc_pc_i = 32'h80001000; status_i = 32'h0000FF01;
    #1;
    n_checks++; if (cp0_we_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL exc_accept got we=%0b busy=%0b want 0/0", cp0_we_o, busy_o); end
    next_cycle();
    exc_req_i = 1'b0; eret_i = 1'b1; epc_i = 32'hDEAD0000;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h80001000}) begin n_fail++; $display("FAIL exc_epc_wr got we=%0b a=%0d d=%h want 1/14/80001000", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if ({stall_o, flush_o, busy_o} !== 3'b101 || exc_code_o !== 5'h0C) begin n_fail++; $display("FAIL exc_c1_ctl got s/f/b=%b code=%h want 101/0c", {stall_o, flush_o, busy_o}, exc_code_o); end
    next_cycle();
    eret_i = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd12, 32'h0000FF03}) begin n_fail++; $display("FAIL exc_status_wr got we=%0b a=%0d d=%h want 1/12/0000ff03", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'd0) begin n_fail++; $display("FAIL exc_c2_noflush got f=%0b pc=%h want 0/0", flush_o, new_pc_o); end
    next_cycle();
    n_checks++; if ({flush_o, new_pc_o} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL exc_redirect got f=%0b pc=%h want 1/00000020", flush_o, new_pc_o); end
    n_checks++; if ({cp0_we_o, stall_o} !== 2'b00) begin n_fail++; $display("FAIL exc_redirect_we got we/stall=%b want 00", {cp0_we_o, stall_o}); end
    next_cycle();
    n_checks++; if ({busy_o, flush_o, new_pc_o} !== {2'b00, 32'd0}) begin n_fail++; $display("FAIL exc_back_idle got b=%0b f=%0b pc=%h want 0/0/0", busy_o, flush_o, new_pc_o); end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    status_i = 32'h00008001; timer_int_i = 1'b1; exc_pc_i = 32'h80002000;
    next_cycle();
    timer_int_i = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd14, 32'h80002000}) begin n_fail++; $display("FAIL int_epc_wr got we=%0b a=%0d d=%h want 1/14/80002000", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if (exc_code_o !== 5'd0) begin n_fail++; $display("FAIL int_code got %h want 00", exc_code_o); end
    next_cycle();
    n_checks++; if ({cp0_waddr_o, cp0_data_o} !== {5'd12, 32'h00008003}) begin n_fail++; $display("FAIL int_status_wr got a=%0d d=%h want 12/00008003", cp0_waddr_o, cp0_data_o); end
    next_cycle();
    n_checks++; if ({flush_o, new_pc_o} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL int_redirect got f=%0b pc=%h want 1/00000020", flush_o, new_pc_o); end
    next_cycle();
    status_i = 32'h00008003; timer_int_i = 1'b1;
    next_cycle();
    n_checks++; if ({busy_o, stall_o, cp0_we_o} !== 3'b000) begin n_fail++; $display("FAIL int_exl_masked got b/s/we=%b want 000", {busy_o, stall_o, cp0_we_o}); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_eret();
    eret_i = 1'b1; epc_i = 32'h80000200; status_i = 32'h00000003;
    next_cycle();
    eret_i = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd12, 32'h00000001}) begin n_fail++; $display("FAIL eret_status_wr got we=%0b a=%0d d=%h want 1/12/00000001", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL eret_stall got %0b want 1", stall_o); end
    next_cycle();
    n_checks++; if ({flush_o, new_pc_o} !== {1'b1, 32'h80000200}) begin n_fail++; $display("FAIL eret_redirect got f=%0b pc=%h want 1/80000200", flush_o, new_pc_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_priority();
    exc_req_i = 1'b1; exc_code_i = 5'h04; exc_pc_i = 32'h80003000;
    eret_i = 1'b1; epc_i = 32'h80000400;
    mtc0_we_i = 1'b1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h55;
    status_i = 32'h00000003;
    #1;
    n_checks++; if (cp0_we_o !== 1'b0) begin n_fail++; $display("FAIL prio_mtc0_drop got %0b want 0", cp0_we_o); end
    next_cycle();
    exc_req_i = 1'b0; eret_i = 1'b0; mtc0_we_i = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd12, 32'h00000003}) begin n_fail++; $display("FAIL prio_status_wr got we=%0b a=%0d d=%h want 1/12/00000003", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if (exc_code_o !== 5'h04) begin n_fail++; $display("FAIL prio_code got %h want 04", exc_code_o); end
    next_cycle();
    n_checks++; if ({flush_o, new_pc_o} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL prio_redirect got f=%0b pc=%h want 1/00000020", flush_o, new_pc_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_mtc0();
    mtc0_we_i = 1'b1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h100;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o, cp0_data_o} !== {1'b1, 5'd11, 32'h100}) begin n_fail++; $display("FAIL mtc0_pass got we=%0b a=%0d d=%h want 1/11/00000100", cp0_we_o, cp0_waddr_o, cp0_data_o); end
    n_checks++; if ({stall_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL mtc0_nostall got s/b=%b want 00", {stall_o, busy_o}); end
    mtc0_data_i = 32'h200; mtc0_addr_i = 5'd9;
    #1;
    n_checks++; if ({cp0_waddr_o, cp0_data_o} !== {5'd9, 32'h200}) begin n_fail++; $display("FAIL mtc0_comb got a=%0d d=%h want 9/00000200", cp0_waddr_o, cp0_data_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    exc_req_i = 1'b1; exc_code_i = 5'h05; exc_pc_i = 32'h80004000; status_i = 32'h00000001;
    next_cycle();
    exc_req_i = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, cp0_waddr_o} !== {1'b1, 5'd14}) begin n_fail++; $display("FAIL rmid_in_epc got we=%0b a=%0d want 1/14", cp0_we_o, cp0_waddr_o); end
    rst = 1'b0;
    #1;
    n_checks++; if ({cp0_we_o, stall_o, flush_o, busy_o} !== 4'b0000) begin n_fail++; $display("FAIL rmid_async got we/s/f/b=%b want 0000", {cp0_we_o, stall_o, flush_o, busy_o}); end
    n_checks++; if (new_pc_o !== 32'd0 || exc_code_o !== 5'd0) begin n_fail++; $display("FAIL rmid_regs got pc=%h code=%h want 0/0", new_pc_o, exc_code_o); end
    next_cycle();
    rst = 1'b1;
    #1;
    n_checks++; if ({busy_o, cp0_we_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_release got b/we=%b want 00", {busy_o, cp0_we_o}); end
    next_cycle();
    n_checks++; if ({busy_o, cp0_we_o, flush_o} !== 3'b000) begin n_fail++; $display("FAIL rmid_no_pending got b/we/f=%b want 000", {busy_o, cp0_we_o, flush_o}); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt();
    test_eret();
    test_priority();
    test_mtc0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
EXC_SEQ -- requirements
Module: exc_seq

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h00000020, exception entry PC.
REQ-002 Parameter ADDR_STATUS, default 5'd12, CP0 Status register address.
REQ-003 Parameter ADDR_EPC, default 5'd14, CP0 EPC register address.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-low.
REQ-006 exc_req_i  in  1  synchronous exception request from the mem stage.
REQ-007 exc_code_i  in  5  ExcCode of the synchronous exception.
REQ-008 exc_pc_i  in  32  PC of the instruction currently in the mem stage.
REQ-009 eret_i  in  1  ERET instruction in the mem stage.
REQ-010 mtc0_we_i, mtc0_addr_i, mtc0_data_i  in  1/5/32  pipeline MTC0 write request.
REQ-011 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC values.
REQ-012 timer_int_i  in  1  CP0 timer interrupt.
REQ-013 cp0_we_o, cp0_waddr_o, cp0_data_o  out  1/5/32  the single CP0 write port.
REQ-014 stall_o  out  1  holds the pipeline while a sequence runs.
REQ-015 flush_o  out  1  one-cycle pipeline flush.
REQ-016 new_pc_o  out  32  redirect target, valid when flush_o=1.
REQ-017 exc_code_o  out  5  ExcCode of the last accepted event.
REQ-018 busy_o  out  1  high in every state other than IDLE.

Function
REQ-019 int_pend SHALL equal status_i[0] & ~status_i[1] & |(status_i[15:8] & {cause_i[15] | timer_int_i, cause_i[14:8]}).
REQ-020 States SHALL be IDLE, WR_EPC, WR_STATUS, ERET_ST and REDIRECT.
REQ-021 In IDLE, accepted events SHALL follow this priority: exc_req_i, then int_pend, then eret_i, then MTC0 pass-through.
REQ-022 In IDLE with no event, cp0_we/waddr/data_o SHALL equal mtc0_we/addr/data_i combinationally.
REQ-023 On accepting an exception or interrupt, the block SHALL latch exc_pc_i and the code (exc_code_i, or 5'd0 for an interrupt) into exc_code_o.
REQ-024 After that acceptance, the next state SHALL be WR_EPC if status_i[1]=0, else WR_STATUS.
REQ-025 Any MTC0 in the accept cycle SHALL be dropped, with cp0_we_o=0.
REQ-026 WR_EPC: cp0_we_o=1, waddr=ADDR_EPC, data=latched PC; next state WR_STATUS.
REQ-027 WR_STATUS: cp0_we_o=1, waddr=ADDR_STATUS, data=status_i | 32'h2 (set EXL); latch EXC_VECTOR as target; next state REDIRECT.
REQ-028 Accepting ERET SHALL latch epc_i as the target and go to ERET_ST.
REQ-029 ERET_ST: cp0_we_o=1, waddr=ADDR_STATUS, data=status_i & ~32'h2; next state REDIRECT.
REQ-030 REDIRECT: flush_o=1 and new_pc_o=latched target for exactly one cycle; next state IDLE; cp0_we_o=0.
REQ-031 stall_o SHALL be 1 in WR_EPC, WR_STATUS and ERET_ST.
REQ-032 Latency: exception with EXL=0 flushes 3 cycles after acceptance; with EXL=1, 2 cycles; ERET, 2 cycles.
REQ-033 Requests arriving outside IDLE SHALL be ignored; the pipeline holds them under stall_o.
REQ-034 Outside REDIRECT, new_pc_o SHALL be 0 and flush_o SHALL be 0.

Reset
REQ-035 While rst=0, the state SHALL be IDLE; cp0_we_o, flush_o, stall_o and busy_o SHALL be 0; new_pc_o and exc_code_o SHALL be 0; latches SHALL be cleared.
REQ-036 Reset asserted mid-sequence SHALL abort it immediately with no further CP0 writes; the first post-reset cycle is IDLE.

Verification
REQ-037 exc_req_i=1, exc_code_i=5'h0C, exc_pc_i=32'h80001000, status_i=32'h0000FF01 -> cycle1 EPC write 32'h80001000; cycle2 Status write 32'h0000FF03; cycle3 flush_o=1, new_pc_o=32'h20; exc_code_o=5'h0C.
REQ-038 status_i=32'h00008001, timer_int_i=1, no exc_req -> interrupt accepted; exc_code_o=0; EPC write; flush to 32'h20 at cycle3. Repeat with status_i=32'h00008003 -> no acceptance.
REQ-039 eret_i=1, epc_i=32'h80000200, status_i=32'h00000003 -> cycle1 Status write 32'h00000001; cycle2 flush_o=1, new_pc_o=32'h80000200.
REQ-040 exc_req_i, eret_i and mtc0_we_i all 1 with status_i[1]=1 -> exception wins; no EPC write; Status write in cycle1; flush in cycle2; MTC0 dropped.
REQ-041 Idle MTC0 to address 11 with data 32'h100 -> same-cycle cp0_we_o=1, waddr 11, data 32'h100; stall_o=0.
REQ-042 rst=0 asserted during WR_EPC -> all outputs 0 asynchronously; after release, IDLE with no pending write.
